// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive path
//
// Purpose: receiver FSM state encoding, oversample checkpoints, data width
// and the default value read back when the receive FIFO is empty.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } rx_state_t;

  localparam logic [3:0]  OS_MID              = 4'd7;   // centre of the start bit
  localparam logic [3:0]  OS_LAST             = 4'd15;  // one full bit period later
  localparam int          DATA_BITS           = 8;
  localparam logic [31:0] DEFAULT_EMPTY_VALUE = 32'hFFFF_FFFF;

endpackage

// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - serial line, pop handshake and status bundle
//
// Purpose: groups every non-clock/reset signal of uart_rx_fifo.
// Signals: rx (serial in), read_en (pop strobe), clear_err (flag clear),
//          read_data (head byte or empty value), empty, full, overrun,
//          frame_err, parity_err (only with UART_RX_PARITY_EN).
// master: the side driving the line and popping bytes; slave: the receiver.
interface uart_rx_fifo_if;

  logic        rx;
  logic        read_en;
  logic        clear_err;
  logic [31:0] read_data;
  logic        empty;
  logic        full;
  logic        overrun;
  logic        frame_err;
`ifdef UART_RX_PARITY_EN
  logic        parity_err;
`endif

  modport master (
    output rx, read_en, clear_err,
`ifdef UART_RX_PARITY_EN
    input  parity_err,
`endif
    input  read_data, empty, full, overrun, frame_err
  );

  modport slave (
    input  rx, read_en, clear_err,
`ifdef UART_RX_PARITY_EN
    output parity_err,
`endif
    output read_data, empty, full, overrun, frame_err
  );

endinterface

// File: rtl/uart_byte_fifo.sv
// rtl/uart_byte_fifo.sv - synchronous byte FIFO for received characters
//
// Purpose: DEPTH-entry byte queue with registered empty/full.
// Ports: clk, reset (async, active high), i_push/i_data (write),
//        i_pop (read), o_head (byte at read pointer), o_empty, o_full.
// A push while full is accepted only when a pop happens on the same edge;
// a pop while empty is ignored.
module uart_byte_fifo #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_push,
  input  logic [7:0] i_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_empty,
  output logic       o_full
);

  localparam int             PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = 1;
  localparam logic [PTR_W:0] CNT_FULL = DEPTH[PTR_W:0];

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic [PTR_W:0]   w_count_next;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_head    = r_mem[r_rd_ptr];

  always_comb begin
    w_count_next = r_count;
    if (w_do_push && !w_do_pop)
      w_count_next = r_count + CNT_ONE;
    else if (w_do_pop && !w_do_push)
      w_count_next = r_count - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (w_do_push)
      r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      o_empty  <= 1'b1;
      o_full   <= 1'b0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_do_pop)
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= w_count_next;
      o_empty <= (w_count_next == '0);
      o_full  <= (w_count_next == CNT_FULL);
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - oversampling UART receiver feeding a byte FIFO
//
// Purpose: synchronises rx, frames 8N1 characters (8E1 when the macro
// UART_RX_PARITY_EN is defined) using a 16x oversample tick and buffers
// them in uart_byte_fifo.
// Ports: clk, reset (async, active high), bus (uart_rx_fifo_if.slave):
//        rx, read_en, clear_err in; read_data, empty, full, overrun,
//        frame_err (and parity_err with the macro) out.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int          BAUD_DIV    = 27,
  parameter int          FIFO_DEPTH  = 16,
  parameter logic [31:0] EMPTY_VALUE = DEFAULT_EMPTY_VALUE
) (
  input  logic          clk,
  input  logic          reset,
  uart_rx_fifo_if.slave bus
);

  localparam int              DIV_W   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(BAUD_DIV - 1);
  localparam logic [2:0]      IDX_LAST = 3'(DATA_BITS - 1);

  rx_state_t            r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [3:0]           r_os_cnt;
  logic [2:0]           r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_overrun;
  logic                 r_frame_err;
  logic                 w_tick;
  logic                 w_push;
  logic                 w_overrun_set;
  logic [7:0]           w_head;
  logic                 w_empty;
  logic                 w_full;
`ifdef UART_RX_PARITY_EN
  logic                 r_par_bad;
  logic                 r_parity_err;
  assign bus.parity_err = r_parity_err;
`endif

  // Two-flop synchroniser, idles high so reset does not look like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= bus.rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  // Held at 0 in IDLE so the first tick of a frame lands BAUD_DIV clks after
  // the start edge is seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_div_cnt <= '0;
    else if (r_state == IDLE || w_tick)
      r_div_cnt <= '0;
    else
      r_div_cnt <= r_div_cnt + DIV_W'(1);
  end

  assign w_tick = (r_state != IDLE) && (r_div_cnt == DIV_MAX);

`ifdef UART_RX_PARITY_EN
  assign w_push = w_tick && (r_state == STOP) && (r_os_cnt == OS_LAST) && r_rx_s && !r_par_bad;
`else
  assign w_push = w_tick && (r_state == STOP) && (r_os_cnt == OS_LAST) && r_rx_s;
`endif

  // A full FIFO only loses the byte when nothing leaves on the same edge.
  assign w_overrun_set = w_push && w_full && !bus.read_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_os_cnt    <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      if (bus.clear_err) begin
        r_overrun   <= 1'b0;
        r_frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
        r_parity_err <= 1'b0;
`endif
      end
      if (w_overrun_set)
        r_overrun <= 1'b1;

      case (r_state)
        IDLE: begin
          if (!r_rx_s) begin
            r_state  <= START;
            r_os_cnt <= '0;
          end
        end
        START: begin
          if (w_tick) begin
            if (r_os_cnt == OS_MID) begin
              r_os_cnt  <= '0;
              r_bit_idx <= '0;
              r_state   <= r_rx_s ? IDLE : DATA;
            end else begin
              r_os_cnt <= r_os_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (w_tick) begin
            r_os_cnt <= r_os_cnt + 4'd1;
            if (r_os_cnt == OS_LAST) begin
              r_shift   <= {r_rx_s, r_shift[DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                r_state <= PARITY;
`else
                r_state <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (w_tick) begin
            r_os_cnt <= r_os_cnt + 4'd1;
            if (r_os_cnt == OS_LAST) begin
              // Even parity: the parity bit equals the XOR of the data bits.
              r_par_bad <= (r_rx_s != ^r_shift);
              if (r_rx_s != ^r_shift)
                r_parity_err <= 1'b1;
              r_state <= STOP;
            end
          end
        end
`endif
        STOP: begin
          if (w_tick) begin
            r_os_cnt <= r_os_cnt + 4'd1;
            if (r_os_cnt == OS_LAST) begin
              if (r_rx_s) begin
                r_state <= IDLE;
              end else begin
                r_frame_err <= 1'b1;
                r_state     <= WAIT_HIGH;
              end
            end
          end
        end
        WAIT_HIGH: begin
          // A held-low line (break) must return high before a new start bit counts.
          if (r_rx_s)
            r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  uart_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_data  (r_shift),
    .i_pop   (bus.read_en),
    .o_head  (w_head),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.read_data = w_empty ? EMPTY_VALUE : {24'h0, w_head};
  assign bus.empty     = w_empty;
  assign bus.full      = w_full;
  assign bus.overrun   = r_overrun;
  assign bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed scoreboard bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int BIT_CLKS = 32;

  logic clk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;
  logic [7:0] sb [$];

  uart_rx_fifo_if u_if ();

  uart_rx_fifo #(
    .BAUD_DIV    (2),
    .FIFO_DEPTH  (16),
    .EMPTY_VALUE (32'hFFFF_FFFF)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (u_if.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Leaves the caller 1 time unit after a rising edge.
  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic read_one(input string tag);
    logic [7:0] e;
    check({tag, "_sb_has_entry"}, 32'(sb.size() != 0), 32'd1);
    e = (sb.size() != 0) ? sb.pop_front() : 8'h00;
    check({tag, "_data"}, u_if.read_data, {24'h0, e});
    check({tag, "_not_empty"}, 32'(u_if.empty), 32'd0);
    u_if.read_en = 1'b1;
    wait_clk(1);
    u_if.read_en = 1'b0;
  endtask

  // Start bit begins 1 unit after the current edge (E0); the stop bit is
  // sampled by the receiver on edge E0+307, hence the pop placement.
  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input logic pop_at_stop);
    u_if.rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 8; i++) begin
      u_if.rx = data[i];
      wait_clk(BIT_CLKS);
    end
    u_if.rx = stop_bit;
    if (pop_at_stop) begin
      wait_clk(18);
      read_one("pop_at_stop");
      wait_clk(13);
    end else begin
      wait_clk(BIT_CLKS);
    end
  endtask

  task automatic pulse_clear();
    u_if.clear_err = 1'b1;
    wait_clk(1);
    u_if.clear_err = 1'b0;
  endtask

  initial begin
    logic [7:0] partial;
    reset          = 1'b1;
    u_if.rx        = 1'b1;
    u_if.read_en   = 1'b0;
    u_if.clear_err = 1'b0;
    wait_clk(3);
    check("rst_read_data", u_if.read_data, 32'hFFFF_FFFF);
    check("rst_empty", 32'(u_if.empty), 32'd1);
    check("rst_full", 32'(u_if.full), 32'd0);
    check("rst_overrun", 32'(u_if.overrun), 32'd0);
    check("rst_frame_err", 32'(u_if.frame_err), 32'd0);
    reset = 1'b0;
    wait_clk(5);

    // Single byte
    sb.push_back(8'hA5);
    send_frame(8'hA5, 1'b1, 1'b0);
    read_one("a5");
    check("a5_empty_after", 32'(u_if.empty), 32'd1);
    check("a5_data_after", u_if.read_data, 32'hFFFF_FFFF);

    // Back-to-back bytes, then a read while empty
    sb.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, 1'b0);
    sb.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, 1'b0);
    read_one("b2b_0");
    read_one("b2b_1");
    u_if.read_en = 1'b1;
    wait_clk(1);
    u_if.read_en = 1'b0;
    check("empty_read_data", u_if.read_data, 32'hFFFF_FFFF);
    check("empty_read_empty", 32'(u_if.empty), 32'd1);
    check("empty_read_overrun", 32'(u_if.overrun), 32'd0);
    sb.push_back(8'h11);
    send_frame(8'h11, 1'b1, 1'b0);
    read_one("after_empty_read");

    // Overflow: 17 bytes into 16 entries
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(8'(i));
      send_frame(8'(i), 1'b1, 1'b0);
    end
    check("ovf_full", 32'(u_if.full), 32'd1);
    check("ovf_overrun", 32'(u_if.overrun), 32'd1);
    for (int i = 0; i < 16; i++) begin
      read_one("ovf_read");
      if (i == 0) check("ovf_full_after_pop", 32'(u_if.full), 32'd0);
    end
    check("ovf_drained", 32'(u_if.empty), 32'd1);
    pulse_clear();
    check("ovf_cleared", 32'(u_if.overrun), 32'd0);

    // Short glitch on the line
    u_if.rx = 1'b0;
    wait_clk(4);
    u_if.rx = 1'b1;
    wait_clk(80);
    check("glitch_empty", 32'(u_if.empty), 32'd1);
    check("glitch_frame_err", 32'(u_if.frame_err), 32'd0);
    check("glitch_overrun", 32'(u_if.overrun), 32'd0);

    // Low stop bit followed by a break of 3 bit times
    send_frame(8'h5A, 1'b0, 1'b0);
    wait_clk(3 * BIT_CLKS);
    check("ferr_set", 32'(u_if.frame_err), 32'd1);
    check("ferr_no_push", 32'(u_if.empty), 32'd1);
    u_if.rx = 1'b1;
    wait_clk(400);
    check("ferr_no_restart", 32'(u_if.empty), 32'd1);
    check("ferr_sticky", 32'(u_if.frame_err), 32'd1);
    pulse_clear();
    check("ferr_cleared", 32'(u_if.frame_err), 32'd0);
    sb.push_back(8'h42);
    send_frame(8'h42, 1'b1, 1'b0);
    read_one("ferr_recover");

    // Full FIFO with a pop on the stop-sample edge
    for (int i = 0; i < 16; i++) begin
      sb.push_back(8'(8'h20 + i));
      send_frame(8'(8'h20 + i), 1'b1, 1'b0);
    end
    check("fp_full_before", 32'(u_if.full), 32'd1);
    sb.push_back(8'h30);
    send_frame(8'h30, 1'b1, 1'b1);
    check("fp_full_after", 32'(u_if.full), 32'd1);
    check("fp_no_overrun", 32'(u_if.overrun), 32'd0);
    for (int i = 0; i < 16; i++) read_one("fp_read");
    check("fp_drained", 32'(u_if.empty), 32'd1);

    // Reset in the middle of a frame, with a byte already queued
    sb.push_back(8'h99);
    send_frame(8'h99, 1'b1, 1'b0);
    check("mid_rst_queued", 32'(u_if.empty), 32'd0);
    partial = 8'h55;
    u_if.rx = 1'b0;
    wait_clk(BIT_CLKS);
    for (int i = 0; i < 4; i++) begin
      u_if.rx = partial[i];
      wait_clk(BIT_CLKS);
    end
    reset   = 1'b1;
    u_if.rx = 1'b1;
    sb.delete();
    #2;
    check("mid_rst_read_data", u_if.read_data, 32'hFFFF_FFFF);
    check("mid_rst_empty", 32'(u_if.empty), 32'd1);
    check("mid_rst_full", 32'(u_if.full), 32'd0);
    check("mid_rst_overrun", 32'(u_if.overrun), 32'd0);
    check("mid_rst_frame_err", 32'(u_if.frame_err), 32'd0);
    wait_clk(3);
    reset = 1'b0;
    wait_clk(10);
    check("post_rst_empty", 32'(u_if.empty), 32'd1);
    sb.push_back(8'h81);
    send_frame(8'h81, 1'b1, 1'b0);
    read_one("post_rst_81");
    check("post_rst_only_one", 32'(u_if.empty), 32'd1);
    check("post_rst_frame_err", 32'(u_if.frame_err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
